// File: rtl/uart_frame_tx_if.sv
// Word handshake into the UART frame transmitter.
// Master offers data_in/in_valid, slave returns in_ready.
interface uart_frame_tx_if #(
  parameter int DBITS = 8
);
  logic             in_valid;
  logic [DBITS-1:0] data_in;
  logic             in_ready;

  modport master (
    output in_valid,
    output data_in,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  data_in,
    output in_ready
  );
endinterface

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start, LSB-first data, optional parity,
// stop; one-word holding buffer allows back-to-back frames.
module uart_frame_tx #(
  parameter int DBITS      = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk_100MHz,
  input  logic           reset,
  input  logic           sample_tick,
  uart_frame_tx_if.slave s_in,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);

  localparam int TW = $clog2(SB_TICK);
  localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [TW-1:0] T_BIT  = TW'(15);
  localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBITS - 1);
  localparam logic ODD     = (PARITY_ODD != 0);
  localparam logic HAS_PAR = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t           r_state, w_state_n;
  logic [TW-1:0]    r_tick,  w_tick_n;
  logic [BW-1:0]    r_bit,   w_bit_n;
  logic [DBITS-1:0] r_shift, w_shift_n;
  logic             r_par,   w_par_n;
  logic             r_tx,    w_tx_n;
  logic             r_done,  w_done_n;
  logic [DBITS-1:0] r_hold;
  logic             r_full;
  logic             w_load;
  logic             w_accept;

  assign w_accept      = s_in.in_valid & ~r_full;
  assign s_in.in_ready = ~r_full;
  assign tx            = r_tx;
  assign busy          = (r_state != IDLE);
  assign tx_done       = r_done;

  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_done_n  = 1'b0;
    w_load    = 1'b0;
    w_tx_n    = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_tx_n = 1'b1;
        w_load = r_full;
      end
      START: begin
        w_tx_n = 1'b0;
        if (sample_tick) begin
          if (r_tick == T_BIT) begin
            w_tick_n  = '0;
            w_bit_n   = '0;
            w_state_n = DATA;
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end
      end
      DATA: begin
        w_tx_n = r_shift[0];
        if (sample_tick) begin
          if (r_tick == T_BIT) begin
            w_tick_n  = '0;
            w_shift_n = r_shift >> 1;
            if (r_bit == B_LAST)
              w_state_n = HAS_PAR ? PARITY : STOP;
            else
              w_bit_n = r_bit + 1'b1;
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end
      end
      PARITY: begin
        w_tx_n = r_par;
        if (sample_tick) begin
          if (r_tick == T_BIT) begin
            w_tick_n  = '0;
            w_state_n = STOP;
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end
      end
      STOP: begin
        w_tx_n = 1'b1;
        if (sample_tick) begin
          if (r_tick == T_STOP) begin
            w_done_n  = 1'b1;
            w_tick_n  = '0;
            w_state_n = IDLE;
            w_load    = r_full;
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
    // a load from either IDLE or STOP restarts a frame
    if (w_load) begin
      w_state_n = START;
      w_shift_n = r_hold;
      w_par_n   = (^r_hold) ^ ODD;
      w_tick_n  = '0;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
      r_done  <= w_done_n;
      if (w_load) begin
        r_full <= 1'b0;
      end else if (w_accept) begin
        r_full <= 1'b1;
        r_hold <= s_in.data_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: default, even/odd parity,
// 2-stop-bit, back-to-back, mid-frame reset and tick stall.
module tb_uart_frame_tx;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       sample_tick;
  logic       tick_en    = 1'b1;
  logic [1:0] div        = 2'd0;
  int         cyc        = 0;
  int         pass_n     = 0;
  int         total_n    = 0;
  int         dc0 = 0, dc1 = 0, dc2 = 0;

  logic tx0, busy0, done0;
  logic tx1, busy1, done1;
  logic tx2, busy2, done2;

  uart_frame_tx_if #(.DBITS(8)) if0 ();
  uart_frame_tx_if #(.DBITS(8)) if1 ();
  uart_frame_tx_if #(.DBITS(8)) if2 ();

  uart_frame_tx #(
    .DBITS(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut0 (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .sample_tick(sample_tick),
    .s_in       (if0.slave),
    .tx         (tx0),
    .busy       (busy0),
    .tx_done    (done0)
  );

  uart_frame_tx #(
    .DBITS(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut1 (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .sample_tick(sample_tick),
    .s_in       (if1.slave),
    .tx         (tx1),
    .busy       (busy1),
    .tx_done    (done1)
  );

  uart_frame_tx #(
    .DBITS(8), .SB_TICK(32), .PARITY_EN(1), .PARITY_ODD(1)
  ) dut2 (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .sample_tick(sample_tick),
    .s_in       (if2.slave),
    .tx         (tx2),
    .busy       (busy2),
    .tx_done    (done2)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // one tick every 4 clocks; gating keeps the phase
  always @(negedge clk_100MHz) div = div + 2'd1;
  assign sample_tick = tick_en & (div == 2'd3);

  always @(posedge clk_100MHz) begin
    cyc <= cyc + 1;
    if (done0) dc0 <= dc0 + 1;
    if (done1) dc1 <= dc1 + 1;
    if (done2) dc2 <= dc2 + 1;
  end

  task automatic nxt();
    @(negedge clk_100MHz);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_100MHz);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if0.in_valid = 1'b1;
    if0.data_in  = 8'hFF;
    repeat (3) nxt();
    total_n++;
    if (tx0 !== 1'b1) $display("FAIL rst_tx got=%b exp=1", tx0);
    else pass_n++;
    total_n++;
    if (busy0 !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy0);
    else pass_n++;
    total_n++;
    if (done0 !== 1'b0) $display("FAIL rst_done got=%b exp=0", done0);
    else pass_n++;
    total_n++;
    if (if0.in_ready !== 1'b1)
      $display("FAIL rst_valid_ignored rdy=%b exp=1", if0.in_ready);
    else pass_n++;
    reset = 1'b0;
    if0.in_valid = 1'b0;
    nxt();
    total_n++;
    if (if0.in_ready !== 1'b1)
      $display("FAIL post_rst_rdy got=%b exp=1", if0.in_ready);
    else pass_n++;
    total_n++;
    if ({busy0, busy1, busy2} !== 3'b000)
      $display("FAIL post_rst_busy got=%b exp=000", {busy0, busy1, busy2});
    else pass_n++;
  endtask

  task automatic test_basic();
    logic [9:0] fb;
    int f, d, s0;
    fb = {1'b1, 8'hA5, 1'b0};
    s0 = dc0;
    if0.in_valid = 1'b1;
    if0.data_in  = 8'hA5;
    nxt();
    if0.in_valid = 1'b0;
    total_n++;
    if (if0.in_ready !== 1'b0)
      $display("FAIL basic_rdy_full got=%b exp=0", if0.in_ready);
    else pass_n++;
    nxt();
    total_n++;
    if (tx0 !== 1'b1 || busy0 !== 1'b1)
      $display("FAIL basic_lat_n1 tx=%b busy=%b exp tx=1 busy=1", tx0, busy0);
    else pass_n++;
    nxt();
    total_n++;
    if (tx0 !== 1'b0) $display("FAIL basic_lat_n2 tx=%b exp=0", tx0);
    else pass_n++;
    f = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_until(f + 32 + 64 * i);
      total_n++;
      if (tx0 !== fb[i])
        $display("FAIL basic_bit%0d got=%b exp=%b", i, tx0, fb[i]);
      else pass_n++;
    end
    d = -1;
    while (cyc < f + 700 && d < 0) begin
      nxt();
      if (done0 === 1'b1) d = cyc - f;
    end
    total_n++;
    if (d < 636 || d > 640)
      $display("FAIL basic_done_time got=%0d exp=636..640", d);
    else pass_n++;
    nxt();
    total_n++;
    if (done0 !== 1'b0 || busy0 !== 1'b0)
      $display("FAIL basic_after_done done=%b busy=%b exp 0 0", done0, busy0);
    else pass_n++;
    total_n++;
    if (dc0 - s0 !== 1)
      $display("FAIL basic_done_count got=%0d exp=1", dc0 - s0);
    else pass_n++;
  endtask

  task automatic test_parity();
    logic [10:0] fb1, fb2;
    int f, s1, s2;
    fb1 = {1'b1, 1'b0, 8'hA5, 1'b0};
    fb2 = {1'b1, 1'b1, 8'hA5, 1'b0};
    s1 = dc1;
    s2 = dc2;
    if1.in_valid = 1'b1;
    if1.data_in  = 8'hA5;
    if2.in_valid = 1'b1;
    if2.data_in  = 8'hA5;
    nxt();
    if1.in_valid = 1'b0;
    if2.in_valid = 1'b0;
    nxt();
    nxt();
    total_n++;
    if (tx1 !== 1'b0 || tx2 !== 1'b0)
      $display("FAIL par_start tx1=%b tx2=%b exp 0 0", tx1, tx2);
    else pass_n++;
    f = cyc;
    for (int i = 0; i < 11; i++) begin
      wait_until(f + 32 + 64 * i);
      total_n++;
      if (tx1 !== fb1[i])
        $display("FAIL par_even_bit%0d got=%b exp=%b", i, tx1, fb1[i]);
      else pass_n++;
      total_n++;
      if (tx2 !== fb2[i])
        $display("FAIL par_odd_bit%0d got=%b exp=%b", i, tx2, fb2[i]);
      else pass_n++;
    end
    wait_until(f + 699);
    total_n++;
    if (busy1 !== 1'b1)
      $display("FAIL par_even_early_end busy=%b exp=1", busy1);
    else pass_n++;
    wait_until(f + 704);
    total_n++;
    if (busy1 !== 1'b0 || dc1 - s1 !== 1)
      $display("FAIL par_even_end busy=%b dones=%0d exp 0 1", busy1, dc1 - s1);
    else pass_n++;
    wait_until(f + 736);
    total_n++;
    if (tx2 !== 1'b1 || busy2 !== 1'b1)
      $display("FAIL sb32_stop_half2 tx=%b busy=%b exp 1 1", tx2, busy2);
    else pass_n++;
    wait_until(f + 763);
    total_n++;
    if (busy2 !== 1'b1 || dc2 - s2 !== 0)
      $display("FAIL sb32_early_end busy=%b dones=%0d exp 1 0", busy2, dc2 - s2);
    else pass_n++;
    wait_until(f + 768);
    total_n++;
    if (busy2 !== 1'b0 || dc2 - s2 !== 1)
      $display("FAIL sb32_end busy=%b dones=%0d exp 0 1", busy2, dc2 - s2);
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] fa, fb;
    int f, f2, d, s0, rdy_bad;
    fa = {1'b1, 8'h55, 1'b0};
    fb = {1'b1, 8'h0F, 1'b0};
    s0 = dc0;
    rdy_bad = 0;
    if0.in_valid = 1'b1;
    if0.data_in  = 8'h55;
    nxt();
    total_n++;
    if (if0.in_ready !== 1'b0)
      $display("FAIL b2b_rdy_hold got=%b exp=0", if0.in_ready);
    else pass_n++;
    if0.data_in = 8'h0F;
    nxt();
    total_n++;
    if (if0.in_ready !== 1'b1)
      $display("FAIL b2b_rdy_load got=%b exp=1", if0.in_ready);
    else pass_n++;
    nxt();
    if0.in_valid = 1'b0;
    total_n++;
    if (if0.in_ready !== 1'b0 || tx0 !== 1'b0)
      $display("FAIL b2b_accept2 rdy=%b tx=%b exp 0 0", if0.in_ready, tx0);
    else pass_n++;
    f = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_until(f + 32 + 64 * i);
      if (if0.in_ready !== 1'b0) rdy_bad++;
      total_n++;
      if (tx0 !== fa[i])
        $display("FAIL b2b_a_bit%0d got=%b exp=%b", i, tx0, fa[i]);
      else pass_n++;
    end
    d = -1;
    while (cyc < f + 700 && d < 0) begin
      nxt();
      if (done0 === 1'b1) d = cyc;
      else if (if0.in_ready !== 1'b0) rdy_bad++;
    end
    total_n++;
    if (rdy_bad != 0 || d < 0)
      $display("FAIL b2b_rdy_low bad=%0d done_at=%0d exp bad=0", rdy_bad, d);
    else pass_n++;
    total_n++;
    if (if0.in_ready !== 1'b1 || tx0 !== 1'b1 || busy0 !== 1'b1)
      $display("FAIL b2b_done_edge rdy=%b tx=%b busy=%b exp 1 1 1",
               if0.in_ready, tx0, busy0);
    else pass_n++;
    nxt();
    total_n++;
    if (tx0 !== 1'b0 || busy0 !== 1'b1)
      $display("FAIL b2b_start2 tx=%b busy=%b exp 0 1", tx0, busy0);
    else pass_n++;
    f2 = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_until(f2 + 32 + 64 * i);
      total_n++;
      if (tx0 !== fb[i])
        $display("FAIL b2b_b_bit%0d got=%b exp=%b", i, tx0, fb[i]);
      else pass_n++;
    end
    wait_until(f2 + 644);
    total_n++;
    if (busy0 !== 1'b0 || dc0 - s0 !== 2)
      $display("FAIL b2b_end busy=%b dones=%0d exp 0 2", busy0, dc0 - s0);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    int f, s0, bad;
    s0  = dc0;
    bad = 0;
    if0.in_valid = 1'b1;
    if0.data_in  = 8'hC3;
    nxt();
    if0.in_valid = 1'b0;
    nxt();
    nxt();
    f = cyc;
    if0.in_valid = 1'b1;
    if0.data_in  = 8'hFF;
    nxt();
    if0.in_valid = 1'b0;
    total_n++;
    if (if0.in_ready !== 1'b0)
      $display("FAIL rmid_buffered rdy=%b exp=0", if0.in_ready);
    else pass_n++;
    wait_until(f + 32 + 64 * 4);
    total_n++;
    if (tx0 !== 1'b0) $display("FAIL rmid_bit3 got=%b exp=0", tx0);
    else pass_n++;
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    total_n++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || if0.in_ready !== 1'b1 ||
        done0 !== 1'b0)
      $display("FAIL rmid_after tx=%b busy=%b rdy=%b done=%b exp 1 0 1 0",
               tx0, busy0, if0.in_ready, done0);
    else pass_n++;
    repeat (800) begin
      nxt();
      if (tx0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0) bad++;
    end
    total_n++;
    if (bad != 0 || dc0 != s0)
      $display("FAIL rmid_quiet bad=%0d dones=%0d exp 0 0", bad, dc0 - s0);
    else pass_n++;
  endtask

  task automatic test_tick_stall();
    logic [9:0] fb;
    int f, d, s0, bad;
    fb  = {1'b1, 8'h81, 1'b0};
    s0  = dc0;
    bad = 0;
    if0.in_valid = 1'b1;
    if0.data_in  = 8'h81;
    nxt();
    if0.in_valid = 1'b0;
    nxt();
    nxt();
    f = cyc;
    wait_until(f + 20);
    tick_en = 1'b0;
    repeat (100) begin
      nxt();
      if (tx0 !== 1'b0 || busy0 !== 1'b1) bad++;
    end
    tick_en = 1'b1;
    total_n++;
    if (bad != 0)
      $display("FAIL stall_hold bad_cycles=%0d exp=0", bad);
    else pass_n++;
    for (int i = 0; i < 10; i++) begin
      wait_until(f + 132 + 64 * i);
      total_n++;
      if (tx0 !== fb[i])
        $display("FAIL stall_bit%0d got=%b exp=%b", i, tx0, fb[i]);
      else pass_n++;
    end
    d = -1;
    while (cyc < f + 800 && d < 0) begin
      nxt();
      if (done0 === 1'b1) d = cyc - f;
    end
    total_n++;
    if (d < 736 || d > 740)
      $display("FAIL stall_done_time got=%0d exp=736..740", d);
    else pass_n++;
    nxt();
    total_n++;
    if (busy0 !== 1'b0 || dc0 - s0 !== 1)
      $display("FAIL stall_end busy=%b dones=%0d exp 0 1", busy0, dc0 - s0);
    else pass_n++;
  endtask

  initial begin
    if0.in_valid = 1'b0;
    if0.data_in  = 8'h00;
    if1.in_valid = 1'b0;
    if1.data_in  = 8'h00;
    if2.in_valid = 1'b0;
    if2.data_in  = 8'h00;
    test_reset();
    repeat (5) nxt();
    test_basic();
    repeat (7) nxt();
    test_parity();
    repeat (9) nxt();
    test_back_to_back();
    repeat (6) nxt();
    test_reset_mid();
    repeat (3) nxt();
    test_tick_stall();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
